// File: rtl/tug_match_ctrl.sv
// Tug of War match controller: turns button presses into movement of a lit
// position, scores points when the light leaves an end, and ends the match.
module tug_match_ctrl #(
  parameter int N_LEDS      = 9,
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_l,
  input  logic              key_r,
  input  logic [2:0]        score_l,
  input  logic [2:0]        score_r,
  output logic [N_LEDS-1:0] led,
  output logic              win_l,
  output logic              win_r,
  output logic              match_over,
  output logic [1:0]        winner
);

  localparam int C      = (N_LEDS - 1) / 2;
  localparam int POS_W  = $clog2(N_LEDS);
  localparam int HOLD_W = $clog2(HOLD_CYCLES);

  localparam logic [POS_W-1:0]  POS_C     = POS_W'(C);
  localparam logic [POS_W-1:0]  POS_MAX   = POS_W'(N_LEDS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [2:0]        SCORE_TGT = 3'(WIN_SCORE);

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    POINT = 2'd1,
    OVER  = 2'd2
  } state_e;

  function automatic logic [N_LEDS-1:0] onehot(input logic [POS_W-1:0] p);
    return {{(N_LEDS-1){1'b0}}, 1'b1} << p;
  endfunction

  // Winner's half of the playfield; the center LED stays dark.
  function automatic logic [N_LEDS-1:0] half_mask(input logic left);
    logic [N_LEDS-1:0] v;
    for (int i = 0; i < N_LEDS; i++) begin
      v[i] = left ? (i > C) : (i < C);
    end
    return v;
  endfunction

  state_e              state_q, state_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                side_l_q, side_l_d;
  logic                prev_l_q, prev_l_d;
  logic                prev_r_q, prev_r_d;
  logic                press_l_q, press_l_d;
  logic                press_r_q, press_r_d;
  logic [N_LEDS-1:0]   led_q, led_d;
  logic                win_l_q, win_l_d;
  logic                win_r_q, win_r_d;
  logic                over_q, over_d;
  logic [1:0]          winner_q, winner_d;

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    hold_d   = hold_q;
    side_l_d = side_l_q;
    over_d   = over_q;
    winner_d = winner_q;
    win_l_d  = 1'b0;
    win_r_d  = 1'b0;
    prev_l_d = key_l;
    prev_r_d = key_r;
    // Edges are only captured while playing, so nothing stale survives a point.
    press_l_d = key_l & ~prev_l_q & (state_q == PLAY);
    press_r_d = key_r & ~prev_r_q & (state_q == PLAY);

    case (state_q)
      PLAY: begin
        if (press_l_q && !press_r_q) begin
          if (pos_q != POS_MAX) begin
            pos_d = pos_q + POS_W'(1);
          end else begin
            win_l_d  = 1'b1;
            side_l_d = 1'b1;
            hold_d   = HOLD_LOAD;
            state_d  = POINT;
          end
        end else if (press_r_q && !press_l_q) begin
          if (pos_q != '0) begin
            pos_d = pos_q - POS_W'(1);
          end else begin
            win_r_d  = 1'b1;
            side_l_d = 1'b0;
            hold_d   = HOLD_LOAD;
            state_d  = POINT;
          end
        end
      end
      POINT: begin
        if (hold_q == '0) begin
          // The score counter has already absorbed this point's pulse.
          if ((side_l_q ? score_l : score_r) == SCORE_TGT) begin
            state_d  = OVER;
            over_d   = 1'b1;
            winner_d = side_l_q ? 2'b10 : 2'b01;
          end else begin
            pos_d   = POS_C;
            state_d = PLAY;
          end
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      OVER: begin
      end
      default: state_d = PLAY;
    endcase

    case (state_d)
      PLAY:    led_d = onehot(pos_d);
      OVER:    led_d = half_mask(winner_d[1]);
      default: led_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= PLAY;
      pos_q     <= POS_C;
      hold_q    <= '0;
      side_l_q  <= 1'b0;
      prev_l_q  <= key_l;
      prev_r_q  <= key_r;
      press_l_q <= 1'b0;
      press_r_q <= 1'b0;
      led_q     <= onehot(POS_C);
      win_l_q   <= 1'b0;
      win_r_q   <= 1'b0;
      over_q    <= 1'b0;
      winner_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      hold_q    <= hold_d;
      side_l_q  <= side_l_d;
      prev_l_q  <= prev_l_d;
      prev_r_q  <= prev_r_d;
      press_l_q <= press_l_d;
      press_r_q <= press_r_d;
      led_q     <= led_d;
      win_l_q   <= win_l_d;
      win_r_q   <= win_r_d;
      over_q    <= over_d;
      winner_q  <= winner_d;
    end
  end

  assign led        = led_q;
  assign win_l      = win_l_q;
  assign win_r      = win_r_q;
  assign match_over = over_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_tug_match_ctrl.sv
// Bench for tug_match_ctrl: directed game scenarios plus random play, checked
// every cycle against a game-level reference model and the score counters.
module tb_tug_match_ctrl;

  localparam int N  = 9;
  localparam int WS = 3;
  localparam int HC = 4;
  localparam int C  = (N - 1) / 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         key_l = 1'b0;
  logic         key_r = 1'b0;
  logic [2:0]   score_l, score_r;
  logic [N-1:0] led;
  logic         win_l, win_r, match_over;
  logic [1:0]   winner;

  always #5 clk = ~clk;

  tug_match_ctrl #(.N_LEDS(N), .WIN_SCORE(WS), .HOLD_CYCLES(HC)) dut (
    .clk(clk), .reset(reset), .key_l(key_l), .key_r(key_r),
    .score_l(score_l), .score_r(score_r), .led(led),
    .win_l(win_l), .win_r(win_r), .match_over(match_over), .winner(winner)
  );

  // Score counters: 3-bit, sync reset, increment on a win pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      score_l <= 3'd0;
      score_r <= 3'd0;
    end else begin
      if (win_l) score_l <= score_l + 3'd1;
      if (win_r) score_r <= score_r + 3'd1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_wl   = 0;
  int cnt_wr   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 = playing, 1 = holding after a point, 2 = match over.
  int m_phase = 0, m_pos = C, m_hold_left = 0, m_winner = 0;
  int m_sc_l = 0, m_sc_r = 0;
  bit m_side_left = 0, m_pend_l = 0, m_pend_r = 0, m_prev_l = 0, m_prev_r = 0;
  bit m_win_l = 0, m_win_r = 0;

  function automatic logic [N-1:0] exp_led();
    logic [N-1:0] v;
    v = '0;
    if (m_phase == 0) begin
      v[m_pos] = 1'b1;
    end else if (m_phase == 2) begin
      for (int i = 0; i < N; i++) begin
        if (m_winner == 2 && i > C) v[i] = 1'b1;
        if (m_winner == 1 && i < C) v[i] = 1'b1;
      end
    end
    return v;
  endfunction

  task automatic model_edge(input bit kl, input bit kr, input bit rst);
    bit new_l, new_r, was_wl, was_wr;
    int s;
    if (rst) begin
      m_phase = 0; m_pos = C; m_hold_left = 0; m_winner = 0;
      m_sc_l = 0; m_sc_r = 0; m_pend_l = 0; m_pend_r = 0;
      m_prev_l = kl; m_prev_r = kr; m_win_l = 0; m_win_r = 0;
      return;
    end
    new_l  = kl && !m_prev_l && (m_phase == 0);
    new_r  = kr && !m_prev_r && (m_phase == 0);
    was_wl = m_win_l;
    was_wr = m_win_r;
    m_win_l = 0;
    m_win_r = 0;
    if (m_phase == 0) begin
      if (m_pend_l && !m_pend_r) begin
        if (m_pos < N - 1) m_pos++;
        else begin m_win_l = 1; m_side_left = 1; m_phase = 1; m_hold_left = HC; end
      end else if (m_pend_r && !m_pend_l) begin
        if (m_pos > 0) m_pos--;
        else begin m_win_r = 1; m_side_left = 0; m_phase = 1; m_hold_left = HC; end
      end
    end else if (m_phase == 1) begin
      m_hold_left--;
      if (m_hold_left == 0) begin
        s = m_side_left ? m_sc_l : m_sc_r;
        if (s == WS) begin
          m_phase  = 2;
          m_winner = m_side_left ? 2 : 1;
        end else begin
          m_phase = 0;
          m_pos   = C;
        end
      end
    end
    if (was_wl) m_sc_l++;
    if (was_wr) m_sc_r++;
    m_pend_l = new_l;
    m_pend_r = new_r;
    m_prev_l = kl;
    m_prev_r = kr;
  endtask

  task automatic step(input bit kl, input bit kr, input bit rst);
    @(negedge clk);
    key_l = kl;
    key_r = kr;
    reset = rst;
    @(posedge clk);
    model_edge(kl, kr, rst);
    #1;
    if (win_l) cnt_wl++;
    if (win_r) cnt_wr++;
    check_eq("led", led, exp_led());
    check_eq("win_l", win_l, m_win_l);
    check_eq("win_r", win_r, m_win_r);
    check_eq("match_over", match_over, m_phase == 2);
    check_eq("winner", winner, m_winner);
    check_eq("score_l", score_l, m_sc_l);
    check_eq("score_r", score_r, m_sc_r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic press_l();
    step(1, 0, 0);
    idle(2);
  endtask

  task automatic press_r();
    step(0, 1, 0);
    idle(2);
  endtask

  task automatic do_reset();
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 0);
  endtask

  task automatic left_point();
    for (int i = 0; i < 5; i++) press_l();
    idle(4);
  endtask

  initial begin
    // Reset state
    do_reset();
    check_eq("rst_led", led, 9'b000010000);
    check_eq("rst_win", {30'd0, win_l, win_r}, 0);
    check_eq("rst_over", match_over, 0);
    check_eq("rst_winner", winner, 2'b00);

    // Left walks to the end and scores
    cnt_wl = 0; cnt_wr = 0;
    for (int i = 0; i < 4; i++) press_l();
    check_eq("walk_led8", led, 9'b100000000);
    press_l();
    check_eq("point_dark", led, 9'b000000000);
    idle(4);
    check_eq("left_pulses", cnt_wl, 1);
    check_eq("left_score", score_l, 3'd1);
    check_eq("left_recenter", led, 9'b000010000);

    // Simultaneous presses and a held key
    cnt_wl = 0; cnt_wr = 0;
    step(1, 1, 0);
    idle(2);
    check_eq("both_led", led, 9'b000010000);
    check_eq("both_pulses", cnt_wl + cnt_wr, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 0);
    idle(1);
    check_eq("held_led", led, 9'b000100000);

    // Right scores; presses during the hold are ignored
    press_r();
    check_eq("recenter_r", led, 9'b000010000);
    cnt_wl = 0; cnt_wr = 0;
    for (int i = 0; i < 5; i++) press_r();
    step(1, 1, 0);
    step(0, 0, 0);
    step(1, 1, 0);
    idle(3);
    check_eq("hold_ign_led", led, 9'b000010000);
    check_eq("hold_ign_score_r", score_r, 3'd1);
    check_eq("hold_ign_wr", cnt_wr, 1);
    check_eq("hold_ign_wl", cnt_wl, 0);

    // Match end
    do_reset();
    for (int p = 0; p < 3; p++) left_point();
    check_eq("end_over", match_over, 1);
    check_eq("end_winner", winner, 2'b10);
    check_eq("end_led", led, 9'b111100000);
    cnt_wl = 0; cnt_wr = 0;
    for (int i = 0; i < 3; i++) begin press_l(); press_r(); end
    check_eq("end_pulses", cnt_wl + cnt_wr, 0);
    check_eq("end_score_l", score_l, 3'd3);
    check_eq("end_score_r", score_r, 3'd0);

    // Reset in OVER
    step(0, 0, 1);
    check_eq("rst_over_led", led, 9'b000010000);
    check_eq("rst_over_over", match_over, 0);
    check_eq("rst_over_winner", winner, 2'b00);
    check_eq("rst_over_score", score_l, 3'd0);

    // Reset mid-POINT
    step(0, 0, 0);
    for (int i = 0; i < 5; i++) press_l();
    step(0, 0, 1);
    check_eq("rst_pt_led", led, 9'b000010000);
    check_eq("rst_pt_over", match_over, 0);
    check_eq("rst_pt_score", score_l, 3'd0);

    // Random play with occasional resets
    step(0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 499) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tug_match_ctrl.md
# tug_match_ctrl

Match controller for the Tug of War game. It turns two player buttons into movement of a single lit position on an LED playfield and detects when a player pulls the light off their end. For each point it emits a one-cycle win pulse that drives the per-player score counters (3-bit, sync reset, increment on `win`). It pauses between points and ends the match when either player's score reaches the target.

## Interface
Parameters:
- `N_LEDS`, 9: playfield width. Must be odd and ≥ 3. Center index is `C = (N_LEDS-1)/2`.
- `WIN_SCORE`, 7: points needed to win the match. Range 1..7, so the 3-bit counters never wrap.
- `HOLD_CYCLES`, 50_000_000: length of the pause after each point, in clk cycles. Must be ≥ 2.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high. Shared with the score counters.
- `key_l`  in  1: left player button, active-high, already synchronized to clk.
- `key_r`  in  1: right player button, active-high, already synchronized to clk.
- `score_l`  in  3: left score counter output.
- `score_r`  in  3: right score counter output.
- `led`  out  N_LEDS: playfield. `led[N_LEDS-1]` is the leftmost LED, `led[0]` the rightmost.
- `win_l`  out  1: one-cycle increment pulse to the left score counter.
- `win_r`  out  1: one-cycle increment pulse to the right score counter.
- `match_over`  out  1: high while the match is finished.
- `winner`  out  2: 2'b10 = left won, 2'b01 = right won, 2'b00 = no winner yet.

## Operation
- **Press detection.** A press is a rising edge of a key: `key` is 1 and the registered previous value is 0.
  - During reset, the previous-value registers load the current key levels. A key held across reset release therefore produces no press.
- **Position register.** `pos` ranges 0..N_LEDS-1 and resets to C.
- **States:** PLAY, POINT, OVER. Reset enters PLAY.
- **PLAY**
  - `led` is one-hot at `pos`.
  - Left press only: if `pos < N_LEDS-1`, `pos` increments. Otherwise `win_l` is asserted for 1 cycle, the side is latched as left, and the FSM goes to POINT.
  - Right press only: if `pos > 0`, `pos` decrements. Otherwise `win_r` is asserted for 1 cycle, the side is latched as right, and the FSM goes to POINT.
  - Both pressed in the same cycle: no movement and no point. Both edges are consumed.
- **POINT**
  - `led` is all zeros and all keys are ignored. Previous-value registers keep tracking, so no stale edges remain.
  - The hold counter loads `HOLD_CYCLES-1` on entry and decrements each cycle.
  - At zero, the controller checks the latched side's score, which the counter has already updated:
    - If that score equals `WIN_SCORE`: go to OVER and set `winner` to the latched side.
    - Otherwise: set `pos` to C and return to PLAY.
- **OVER**
  - `match_over` is 1.
  - `led` lights the winner's half: indices C+1..N_LEDS-1 if left won, 0..C-1 if right won. The center LED is off.
  - Keys are ignored and no win pulses are issued.
  - The only exit is reset.
- **Pulse rules.** `win_l` and `win_r` are never both high. Each point produces exactly one pulse, so a score increments by exactly 1 per point.

## Timing
- All outputs are registered.
- Reset values: `led` one-hot at C, `win_l`=0, `win_r`=0, `match_over`=0, `winner`=00, state PLAY, `pos`=C, hold counter 0.
- Press to LED move: a key edge sampled at edge k shows the new `led` after edge k+1 (1-cycle latency).
- Scoring press at edge k:
  - `win_x`=1 during cycle k+1 and `led`=0 from k+1.
  - The score counter shows the new value after edge k+2.
  - PLAY (or OVER) resumes at edge k+1+HOLD_CYCLES.
- Reset mid-POINT or in OVER: returns to PLAY at the center within 1 cycle. The score counters clear on the same edge.

## Test plan
(N_LEDS=9, WIN_SCORE=3, HOLD_CYCLES=4)
- **Reset.** Reset for 2 cycles, then release → `led`=9'b000010000, `win_l`=`win_r`=0, `match_over`=0, `winner`=00.
- **Left scores.** 5 left presses spaced 3 cycles apart → `led` walks through bits 5,6,7,8. The 5th press gives `win_l` high exactly 1 cycle, `led`=0 for 4 cycles, `score_l`=1, then `led` returns to the center.
- **Simultaneous and held keys.** `key_l` and `key_r` rise on the same cycle → `led` is unchanged and there is no pulse. `key_l` held high for 20 cycles → exactly 1 move.
- **Keys ignored during POINT.** Right scores (5 right presses), then presses on both keys during the 4 hold cycles → no movement and no pulses. Play resumes at the center, `score_r`=1.
- **Match end.** Left scores 3 points → after the 3rd hold, `match_over`=1, `winner`=10, `led`=9'b111100000. Further presses produce no pulses and the scores stay 3/0.
- **Reset mid-operation.** Reset asserted mid-POINT and again in OVER → next cycle shows the center LED, `match_over`=0, `winner`=00, scores 0.
